// File: rtl/alu_mdu_controller.sv
// ALU operation decoder plus an iterative multiply/divide unit for the execute stage.
// Multiply is shift-add and divide is restoring; both work on operand magnitudes, one bit per cycle.
module alu_mdu_controller #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            RegType,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            flush,
    output logic [3:0]      Operation,
    output logic            stall,
    output logic            mdu_valid,
    output logic [XLEN-1:0] mdu_result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [6:0] F7_MDU = 7'b0000001;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] hi, hi_n;
    logic [XLEN-1:0] lo, lo_n;
    logic [XLEN-1:0] opd, opd_n;
    logic [XLEN-1:0] res_n;
    logic [1:0]      fn, fn_n;
    logic            neg_q, neg_q_n;
    logic            neg_r, neg_r_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            valid_n;

    logic            is_mop;

    assign is_mop = in_valid && (ALUOp == 2'b10) && RegType && (Funct7 == F7_MDU);

    // ALU operation decode; M-ops leave the ALU idle
    always_comb begin
        Operation = 4'b0000;
        case (ALUOp)
            2'b00: Operation = 4'b0010;
            2'b01: begin
                case (Funct3)
                    3'b000:  Operation = 4'b1000;
                    3'b001:  Operation = 4'b1011;
                    3'b100:  Operation = 4'b1100;
                    3'b101:  Operation = 4'b1101;
                    default: Operation = 4'b0000;
                endcase
            end
            2'b10: begin
                case (Funct3)
                    3'b000: Operation = (RegType && (Funct7 == F7_ALT)) ? 4'b0001 : 4'b0010;
                    3'b001: Operation = 4'b0101;
                    3'b010: Operation = 4'b1001;
                    3'b011: Operation = 4'b1010;
                    3'b100: Operation = 4'b0100;
                    3'b101: Operation = (Funct7 == F7_ALT) ? 4'b0111 : 4'b0110;
                    3'b110: Operation = 4'b0011;
                    3'b111: Operation = 4'b0000;
                endcase
            end
            2'b11: Operation = 4'b0000;
        endcase
        if (is_mop) begin
            Operation = 4'b0000;
        end
    end

    // Operand setup at acceptance: signedness per funct3, magnitudes and special divides
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;

    always_comb begin
        if (Funct3[2]) begin
            a_sgn = !Funct3[0];
            b_sgn = !Funct3[0];
        end else begin
            a_sgn = (Funct3[1:0] != 2'b11);
            b_sgn = !Funct3[1];
        end
        a_neg    = a_sgn && SrcA[XLEN-1];
        b_neg    = b_sgn && SrcB[XLEN-1];
        mag_a    = a_neg ? -SrcA : SrcA;
        mag_b    = b_neg ? -SrcB : SrcB;
        div_zero = (SrcB == '0);
        div_ovf  = !Funct3[0] && (SrcA == MOST_NEG) && (SrcB == '1);
    end

    // One iteration step of each engine, plus final sign correction
    logic [XLEN:0]     mul_sum, div_trial;
    logic [XLEN-1:0]   mul_hi, mul_lo, div_rem, div_quo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;
    logic              div_ge;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opd} : {(XLEN+1){1'b0}});
        mul_hi    = mul_sum[XLEN:1];
        mul_lo    = {mul_sum[0], lo[XLEN-1:1]};
        prod      = {mul_hi, mul_lo};
        prod_s    = neg_q ? -prod : prod;
        div_trial = {hi, lo[XLEN-1]} - {1'b0, opd};
        div_ge    = !div_trial[XLEN];
        div_rem   = div_ge ? div_trial[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
        div_quo   = {lo[XLEN-2:0], div_ge};
        quo_s     = neg_q ? -div_quo : div_quo;
        rem_s     = neg_r ? -div_rem : div_rem;
    end

    // Next-state and datapath control
    always_comb begin
        state_n = state;
        hi_n    = hi;
        lo_n    = lo;
        opd_n   = opd;
        fn_n    = fn;
        neg_q_n = neg_q;
        neg_r_n = neg_r;
        cnt_n   = cnt;
        res_n   = mdu_result;
        valid_n = 1'b0;
        stall   = 1'b0;
        case (state)
            IDLE: begin
                stall = is_mop;
                if (is_mop && !flush) begin
                    fn_n    = Funct3[1:0];
                    cnt_n   = '0;
                    hi_n    = '0;
                    neg_q_n = a_neg ^ b_neg;
                    neg_r_n = a_neg;
                    if (!Funct3[2]) begin
                        state_n = MUL;
                        lo_n    = mag_b;
                        opd_n   = mag_a;
                    end else if (div_zero) begin
                        state_n = DONE;
                        valid_n = 1'b1;
                        res_n   = Funct3[1] ? SrcA : '1;
                    end else if (div_ovf) begin
                        state_n = DONE;
                        valid_n = 1'b1;
                        res_n   = Funct3[1] ? '0 : SrcA;
                    end else begin
                        state_n = DIV;
                        lo_n    = mag_a;
                        opd_n   = mag_b;
                    end
                end
            end
            MUL: begin
                stall = 1'b1;
                hi_n  = mul_hi;
                lo_n  = mul_lo;
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(XLEN - 1)) begin
                    state_n = DONE;
                    valid_n = 1'b1;
                    res_n   = (fn == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
                end
            end
            DIV: begin
                stall = 1'b1;
                hi_n  = div_rem;
                lo_n  = div_quo;
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(XLEN - 1)) begin
                    state_n = DONE;
                    valid_n = 1'b1;
                    res_n   = fn[1] ? rem_s : quo_s;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) begin
            state_n = IDLE;
            valid_n = 1'b0;
            res_n   = mdu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hi         <= '0;
            lo         <= '0;
            opd        <= '0;
            fn         <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            cnt        <= '0;
            mdu_valid  <= 1'b0;
            mdu_result <= '0;
        end else begin
            state      <= state_n;
            hi         <= hi_n;
            lo         <= lo_n;
            opd        <= opd_n;
            fn         <= fn_n;
            neg_q      <= neg_q_n;
            neg_r      <= neg_r_n;
            cnt        <= cnt_n;
            mdu_valid  <= valid_n;
            mdu_result <= res_n;
        end
    end

endmodule

// File: doc/alu_mdu_controller.md
ALU_MDU_CONTROLLER -- requirements
Module: alu_mdu_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits (even, >= 8).
REQ-002 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n input 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid input 1: execute stage holds a valid instruction.
REQ-005 SHALL have port ALUOp input 2: 00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
REQ-006 SHALL have port Funct7 input 7: instruction bits 31:25.
REQ-007 SHALL have port Funct3 input 3: instruction bits 14:12.
REQ-008 SHALL have port RegType input 1: 1 = R-type (Funct7 valid), 0 = I-type.
REQ-009 SHALL have ports SrcA, SrcB input XLEN: MDU operands (rs1, rs2).
REQ-010 SHALL have port flush input 1: synchronous abort of any MDU operation.
REQ-011 SHALL have port Operation output 4: combinational ALU operation select.
REQ-012 SHALL have port stall output 1: hold pipeline while the MDU is busy.
REQ-013 SHALL have port mdu_valid output 1: single-cycle pulse, mdu_result valid.
REQ-014 SHALL have port mdu_result output XLEN: registered MDU result.

Function
REQ-015 Operation SHALL be: ALUOp 00 -> 0010; 11 -> 0000.
REQ-016 ALUOp 01, by Funct3: 000 -> 1000 (BEQ), 001 -> 1011 (BNE), 100 -> 1100 (BLT), 101 -> 1101 (BGE), other -> 0000.
REQ-017 ALUOp 10, by Funct3: 000 -> 0001 (SUB, only if RegType and Funct7 = 0100000), else 0010; 001 -> 0101; 010 -> 1001; 011 -> 1010; 100 -> 0100; 101 -> 0111 if Funct7 = 0100000, else 0110; 110 -> 0011; 111 -> 0000.
REQ-018 M-op SHALL mean in_valid, ALUOp = 10, RegType = 1 and Funct7 = 0000001; for an M-op Operation SHALL be 0000.
REQ-019 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-020 In IDLE, an M-op SHALL latch SrcA, SrcB and Funct3, and go to MUL (Funct3[2] = 0) or DIV (Funct3[2] = 1); that cycle is T.
REQ-021 stall SHALL be combinationally 1 in IDLE when an M-op is present, and 1 in MUL and DIV; it SHALL be 0 in DONE and in IDLE otherwise.
REQ-022 MUL: shift-add on operand magnitudes for XLEN cycles, then sign correction. MUL -> low XLEN bits; MULH -> high, signed x signed; MULHSU -> high, signed x unsigned; MULHU -> high, unsigned.
REQ-023 DIV: restoring division on magnitudes for XLEN cycles. Quotient sign = sign(A) xor sign(B); remainder sign = sign(A). DIV/REM are signed; DIVU/REMU are unsigned.
REQ-024 Normal latency: MUL/DIV run cycles T+1..T+XLEN; DONE is at T+XLEN+1, where mdu_valid = 1 and mdu_result is final.
REQ-025 Divide by zero: quotient all-ones, remainder = SrcA; the FSM SHALL skip iteration, with DONE at T+1.
REQ-026 Signed overflow (DIV/REM, SrcA = most-negative, SrcB = all-ones): quotient = SrcA, remainder = 0; DONE at T+1.
REQ-027 DONE SHALL always return to IDLE and SHALL NOT accept a new op; the held M-op is not re-issued.
REQ-028 Inputs other than flush SHALL be ignored in MUL, DIV and DONE.
REQ-029 flush SHALL force IDLE on the next edge from any state and suppress mdu_valid. If flush and an M-op arrive together in IDLE, flush wins and the op is not accepted.
REQ-030 mdu_result SHALL hold its last value until the next DONE.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, mdu_valid = 0, mdu_result = 0, and iteration counter and operand registers = 0.
REQ-032 Reset mid-operation SHALL abandon the op with no mdu_valid. Operation SHALL stay purely combinational during reset.

Verification
REQ-033 ALUOp = 10, Funct3 = 101, Funct7 = 0100000, RegType = 1 -> Operation = 0111, stall = 0, no FSM activity; ALUOp = 01, Funct3 = 001 -> 1011.
REQ-034 MUL, SrcA = 7, SrcB = 0xFFFFFFFD -> stall high T..T+32, mdu_valid only at T+33, mdu_result = 0xFFFFFFEB.
REQ-035 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-036 DIV 5/0 -> 0xFFFFFFFF at T+1; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-037 flush at T+10 of a DIVU -> IDLE at T+11, no mdu_valid, stall = 0; an M-op applied next SHALL be accepted normally.
REQ-038 rst_n low at T+5 of a MUL -> outputs reset asynchronously; after release, mdu_valid stays 0 until a new M-op completes.
